// File: rtl/pipeline_timer_irq.sv
// Purpose : memory-mapped interval timer (TH/TL/TCON) plus free-running SYSTICK,
//           raising a registered IRQ toward the pipeline, masked in kernel mode.
// Latency : stores land at the edge ending the MEM cycle; loads are combinational
//           from current state; IRQ follows STATUS/IRQ_EN/PC_kernel by one edge.
// Backpr. : none; the bus is single-cycle and every access completes in its cycle.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   Addr, WriteData   MEM-stage byte address and store data
//   MemWrite, MemRead store / load strobes
//   PC_kernel         PC[31] of the IF instruction, masks IRQ when set
//   ReadData          load data (zero when not a mapped load)
//   IRQ               registered interrupt request
module pipeline_timer_irq #(
    parameter logic [31:0] ADDR_TH      = 32'h4000_0000,
    parameter logic [31:0] ADDR_TL      = 32'h4000_0004,
    parameter logic [31:0] ADDR_TCON    = 32'h4000_0008,
    parameter logic [31:0] ADDR_SYSTICK = 32'h4000_0014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        PC_kernel,
    output logic [31:0] ReadData,
    output logic        IRQ
);

    // TCON bit positions
    localparam int EN     = 0;
    localparam int IRQ_EN = 1;
    localparam int STATUS = 2;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [31:0] systick_q, systick_d;
    logic        irq_q, irq_d;

    logic wr_th, wr_tl, wr_tcon;
    logic ovf;

    assign wr_th   = MemWrite && (Addr == ADDR_TH);
    assign wr_tl   = MemWrite && (Addr == ADDR_TL);
    assign wr_tcon = MemWrite && (Addr == ADDR_TCON);

    always_comb begin
        th_d      = wr_th ? WriteData : th_q;
        systick_d = systick_q + 32'd1;

        // A store to TL overrides counting entirely, so it also suppresses
        // the overflow event that the current value would have produced.
        ovf  = 1'b0;
        tl_d = tl_q;
        if (wr_tl) begin
            tl_d = WriteData;
        end else if (tcon_q[EN]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                ovf  = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        // STATUS is sticky; an overflow only sets it when the IRQ_EN that
        // will be in effect after this edge is high (store value wins).
        if (wr_tcon) begin
            tcon_d = {WriteData[STATUS] | (ovf & WriteData[IRQ_EN]),
                      WriteData[1:0]};
        end else begin
            tcon_d = {tcon_q[STATUS] | (ovf & tcon_q[IRQ_EN]),
                      tcon_q[1:0]};
        end

        irq_d = tcon_q[IRQ_EN] & tcon_q[STATUS] & ~PC_kernel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= 32'd0;
            tl_q      <= 32'd0;
            tcon_q    <= 3'b000;
            systick_q <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        ReadData = 32'd0;
        if (MemRead) begin
            if      (Addr == ADDR_TH)      ReadData = th_q;
            else if (Addr == ADDR_TL)      ReadData = tl_q;
            else if (Addr == ADDR_TCON)    ReadData = {29'd0, tcon_q};
            else if (Addr == ADDR_SYSTICK) ReadData = systick_q;
        end
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_pipeline_timer_irq.sv
// Purpose : directed-vector bench for pipeline_timer_irq with a queue scoreboard.
// Latency : stimulus pushes expectations; a negedge monitor pops and compares.
// Backpr. : none; one bus access per clock.
module tb_pipeline_timer_irq;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_SYS  = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic        PC_kernel;
    logic [31:0] ReadData;
    logic        IRQ;

    pipeline_timer_irq dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .PC_kernel (PC_kernel),
        .ReadData  (ReadData),
        .IRQ       (IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t irq_q[$];

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cnt    = 0;   // edges since last reset edge == SYSTICK value
    logic rd_chk  = 1'b0;
    logic irq_chk = 1'b0;

    // Monitor: samples mid-cycle, when inputs and combinational ReadData are stable.
    always @(negedge clk) begin
        exp_t e;
        if (rd_chk) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_underflow: ReadData=%h but no expectation queued", ReadData);
            end else begin
                e = rd_q.pop_front();
                if (ReadData !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: ReadData got %h expected %h", e.name, ReadData, e.val);
                end
            end
        end
        if (irq_chk) begin
            n_cmp++;
            if (irq_q.size() == 0) begin
                n_fail++;
                $display("FAIL irq_underflow: IRQ=%b but no expectation queued", IRQ);
            end else begin
                e = irq_q.pop_front();
                if (IRQ !== e.val[0]) begin
                    n_fail++;
                    $display("FAIL %s: IRQ got %b expected %b", e.name, IRQ, e.val[0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        if (reset) cnt = 0;
        else       cnt = cnt + 1;
        #1;
        rd_chk  = 1'b0;
        irq_chk = 1'b0;
    endtask

    task automatic idle();
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr      = a;
        WriteData = d;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        step();
        MemWrite  = 1'b0;
        WriteData = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        Addr     = a;
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        rd_q.push_back('{n, e});
        rd_chk   = 1'b1;
        step();
        MemRead  = 1'b0;
    endtask

    // Address presented with MemRead low: output must stay zero.
    task automatic rd_nore(input logic [31:0] a, input string n);
        Addr     = a;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        rd_q.push_back('{n, 32'd0});
        rd_chk   = 1'b1;
        step();
    endtask

    // Checked in the next cycle issued by any stimulus task.
    task automatic exp_irq(input logic e, input string n);
        irq_q.push_back('{n, {31'd0, e}});
        irq_chk = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        Addr      = 32'd0;
        WriteData = 32'd0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PC_kernel = 1'b0;
        step();
        exp_irq(1'b0, "irq_in_reset");
        step();
        reset = 1'b0;

        // Reset state and SYSTICK free-run
        rd(A_SYS, 32'd0, "systick_after_reset");
        repeat (9) idle();
        rd(A_SYS, 32'd10, "systick_10");
        exp_irq(1'b0, "irq_idle");
        rd(A_TH,   32'd0, "th_reset");
        rd(A_TL,   32'd0, "tl_reset");
        rd(A_TCON, 32'd0, "tcon_reset");

        // Reload and interrupt latency
        wr(A_TH,   32'hFFFF_FFFC);
        wr(A_TL,   32'hFFFF_FFFE);
        wr(A_TCON, 32'd3);
        rd(A_TL, 32'hFFFF_FFFE, "tl_no_inc_at_en_edge");
        exp_irq(1'b0, "irq_before_ovf");
        rd(A_TL, 32'hFFFF_FFFF, "tl_inc");
        exp_irq(1'b0, "irq_at_status_edge");
        rd(A_TL, 32'hFFFF_FFFC, "tl_reload");
        exp_irq(1'b1, "irq_one_cycle_later");
        rd(A_TCON, 32'd7, "tcon_status_set");

        // Kernel masking and acknowledge
        PC_kernel = 1'b1;
        idle();
        exp_irq(1'b0, "irq_kernel_mask");
        PC_kernel = 1'b0;
        idle();
        exp_irq(1'b1, "irq_user_again");
        wr(A_TCON, 32'd1);
        exp_irq(1'b1, "irq_ack_latency");
        rd(A_TCON, 32'd1, "tcon_ack");
        exp_irq(1'b0, "irq_acked");
        rd(A_TL, 32'hFFFF_FFFE, "tl_counting_after_ack");

        // Overflow with IRQ_EN = 0
        idle();
        rd(A_TL, 32'hFFFF_FFFC, "tl_reload_noirq");
        exp_irq(1'b0, "irq_noirq_en");
        rd(A_TCON, 32'd1, "status_noirq_en");

        // Store to TL in the overflow cycle wins
        wr(A_TCON, 32'd3);
        wr(A_TL, 32'h0000_1234);
        rd(A_TL, 32'h0000_1234, "tl_store_wins");
        exp_irq(1'b0, "irq_no_ovf");
        rd(A_TCON, 32'd3, "status_no_ovf");

        // Store to TCON in the overflow cycle: new IRQ_EN gates STATUS
        wr(A_TCON, 32'd1);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'd3);
        exp_irq(1'b0, "irq_before_tcon_ovf");
        rd(A_TCON, 32'd7, "tcon_store_ovf");
        exp_irq(1'b1, "irq_after_tcon_ovf");
        rd(A_TL, 32'hFFFF_FFFD, "tl_after_tcon_ovf");

        // Ignored stores, unmapped load, load without MemRead
        wr(32'h4000_000C, 32'hFFFF_FFFF);
        wr(A_SYS, 32'd0);
        rd(A_TH,   32'hFFFF_FFFC, "th_unmapped_store");
        rd(A_TCON, 32'd7,         "tcon_unmapped_store");
        rd(A_SYS,  cnt,           "systick_read_only");
        rd(32'h4000_0010, 32'd0,  "unmapped_load");
        rd_nore(A_TH, "no_memread");

        // Reset mid-count clears everything and counting stays stopped
        reset = 1'b1;
        exp_irq(1'b1, "irq_before_midreset");
        idle();
        reset = 1'b0;
        exp_irq(1'b0, "irq_after_midreset");
        rd(A_TCON, 32'd0, "tcon_midreset");
        rd(A_TL,   32'd0, "tl_midreset");
        rd(A_TH,   32'd0, "th_midreset");
        repeat (3) idle();
        rd(A_TL,  32'd0, "tl_stays_stopped");
        rd(A_SYS, cnt,   "systick_after_midreset");

        idle();
        idle();
        n_cmp++;
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d/%0d pending expected 0/0",
                     rd_q.size(), irq_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
